// File: rtl/vram_writer.sv
// VGA cell-bitmap write stage: set/clear/toggle and swept clear-all.
// Define VRAM_DOUBLE_BUFFER_EN for a frame-synchronous front/back bitmap.
module vram_writer #(
  parameter int CELLS = 100,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_op,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             vsync,
  output logic [CELLS-1:0] video_memory,
  output logic             busy,
  output logic             err,
  output logic             swap
);

  localparam logic [IDX_W:0] NCELL =
    (IDX_W+1)'(CELLS);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(CELLS-1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CELLS-1:0] work_q;
  logic [CELLS-1:0] work_d;
  logic [CELLS-1:0] cell_m;
  logic [CELLS-1:0] sweep_m;
  logic             accept;
  logic             in_range;

  assign accept   = wr_valid && wr_ready;
  assign in_range = {1'b0, wr_idx} < NCELL;
  assign cell_m   = CELLS'(1) << wr_idx;
  assign sweep_m  = CELLS'(1) << ptr;

  always_comb begin
    work_d = work_q;
    if (state == SWEEP) begin
      work_d = work_q & ~sweep_m;
    end else if (accept && in_range) begin
      unique case (wr_op)
        2'b00:   work_d = work_q & ~cell_m;
        2'b01:   work_d = work_q | cell_m;
        2'b10:   work_d = work_q ^ cell_m;
        default: work_d = work_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      work_q   <= '0;
    end else begin
      err    <= 1'b0;
      work_q <= work_d;
      unique case (state)
        IDLE: begin
          wr_ready <= 1'b1;
          if (accept && wr_op == 2'b11) begin
            state    <= SWEEP;
            ptr      <= '0;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
          end else if (accept && !in_range) begin
            err <= 1'b1;
          end
        end
        SWEEP: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == LAST) begin
            state    <= IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VRAM_DOUBLE_BUFFER_EN
  logic [CELLS-1:0] front_q;
  logic             vs_q;
  logic             pend;
  logic             frame_edge;

  assign frame_edge   = vs_q && !vsync;
  assign video_memory = front_q;

  // Edges seen mid-sweep defer to the final sweep edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      front_q <= '0;
      vs_q    <= 1'b1;
      pend    <= 1'b0;
      swap    <= 1'b0;
    end else begin
      vs_q <= vsync;
      swap <= 1'b0;
      if (state == SWEEP) begin
        if (ptr == LAST) begin
          if (pend || frame_edge) begin
            front_q <= work_d;
            swap    <= 1'b1;
          end
          pend <= 1'b0;
        end else if (frame_edge) begin
          pend <= 1'b1;
        end
      end else if (frame_edge) begin
        front_q <= work_q;
        swap    <= 1'b1;
      end
    end
  end
`else
  logic unused_vsync;

  assign unused_vsync = vsync;
  assign video_memory = work_q;
  assign swap         = 1'b0;
`endif

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer (direct build; double-buffer
// cases run when VRAM_DOUBLE_BUFFER_EN is defined).
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_op;
  logic [6:0]  wr_idx;
  logic        vsync;
  logic [99:0] video_memory;
  logic        busy;
  logic        err;
  logic        swap;

  int checks = 0;
  int errors = 0;

  vram_writer dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_op        (wr_op),
    .wr_idx       (wr_idx),
    .vsync        (vsync),
    .video_memory (video_memory),
    .busy         (busy),
    .err          (err),
    .swap         (swap)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input int idx);
    wr_valid = 1'b1;
    wr_op    = op;
    wr_idx   = 7'(idx);
    tick();
    wr_valid = 1'b0;
  endtask

  logic [99:0] exp_vm;
  int          n_busy;
  int          n_swap;
  int          swap_at;
  bit          done;

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_op    = 2'b00;
    wr_idx   = '0;
    vsync    = 1'b1;
    tick();
    tick();
    check("rst_vm", 128'(video_memory), 128'(0));
    check("rst_ready", 128'(wr_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_swap", 128'(swap), 128'(0));
    rst = 1'b0;
    tick();
    check("ready_after_rst", 128'(wr_ready), 128'(1));

`ifndef VRAM_DOUBLE_BUFFER_EN
    // SET 50
    req(2'b01, 50);
    exp_vm     = '0;
    exp_vm[50] = 1'b1;
    check("set50", 128'(video_memory), 128'(exp_vm));

    // SET/TOG/TOG/CLR on cell 3, back to back
    wr_valid = 1'b1;
    wr_idx   = 7'd3;
    wr_op    = 2'b01;
    tick();
    exp_vm[3] = 1'b1;
    check("seq_set3", 128'(video_memory), 128'(exp_vm));
    check("seq_err0", 128'(err), 128'(0));
    wr_op = 2'b10;
    tick();
    exp_vm[3] = 1'b0;
    check("seq_tog3a", 128'(video_memory), 128'(exp_vm));
    check("seq_err1", 128'(err), 128'(0));
    tick();
    exp_vm[3] = 1'b1;
    check("seq_tog3b", 128'(video_memory), 128'(exp_vm));
    check("seq_err2", 128'(err), 128'(0));
    wr_op = 2'b00;
    tick();
    exp_vm[3] = 1'b0;
    check("seq_clr3", 128'(video_memory), 128'(exp_vm));
    check("seq_err3", 128'(err), 128'(0));
    wr_valid = 1'b0;

    // Out-of-range indices
    check("oor_ready", 128'(wr_ready), 128'(1));
    req(2'b01, 100);
    check("oor100_err", 128'(err), 128'(1));
    check("oor100_vm", 128'(video_memory), 128'(exp_vm));
    tick();
    check("oor100_pulse", 128'(err), 128'(0));
    req(2'b01, 127);
    check("oor127_err", 128'(err), 128'(1));
    check("oor127_vm", 128'(video_memory), 128'(exp_vm));
    tick();
    check("oor127_pulse", 128'(err), 128'(0));

    // SET 0, 50, 99 then CLEAR_ALL
    req(2'b01, 0);
    req(2'b01, 50);
    req(2'b01, 99);
    exp_vm[0]  = 1'b1;
    exp_vm[99] = 1'b1;
    check("pre_clear", 128'(video_memory), 128'(exp_vm));
    req(2'b11, 0);
    wr_valid = 1'b1;
    wr_op    = 2'b01;
    wr_idx   = 7'd5;
    n_busy   = 0;
    done     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      n_busy++;
      if (wr_ready)
        check("sweep_ready", 128'(wr_ready), 128'(0));
      if (i == 50)
        check("bit50_e50", 128'(video_memory[50]), 128'(1));
      if (i == 51)
        check("bit50_e51", 128'(video_memory[50]), 128'(0));
      tick();
    end
    check("sweep_done", 128'(done), 128'(1));
    check("sweep_len", 128'(n_busy), 128'(100));
    check("clear_vm", 128'(video_memory), 128'(0));
    check("clear_ready", 128'(wr_ready), 128'(1));
    tick();
    wr_valid = 1'b0;
    exp_vm    = '0;
    exp_vm[5] = 1'b1;
    check("held_req", 128'(video_memory), 128'(exp_vm));
    check("swap_tied", 128'(swap), 128'(0));
`else
    // SET 7 lands in back buffer only
    req(2'b01, 7);
    check("db_set7_front", 128'(video_memory), 128'(0));
    tick();
    check("db_set7_hold", 128'(video_memory), 128'(0));
    check("db_noswap", 128'(swap), 128'(0));
    vsync    = 1'b0;
    wr_valid = 1'b1;
    wr_op    = 2'b01;
    wr_idx   = 7'd8;
    tick();
    wr_valid  = 1'b0;
    exp_vm    = '0;
    exp_vm[7] = 1'b1;
    check("db_swap_vm", 128'(video_memory), 128'(exp_vm));
    check("db_swap", 128'(swap), 128'(1));
    tick();
    check("db_swap_pulse", 128'(swap), 128'(0));
    check("db_no8", 128'(video_memory), 128'(exp_vm));
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    exp_vm[8] = 1'b1;
    check("db_swap2_vm", 128'(video_memory), 128'(exp_vm));
    check("db_swap2", 128'(swap), 128'(1));

    // Two frame edges during a sweep give one swap
    vsync = 1'b1;
    tick();
    req(2'b11, 0);
    n_swap  = 0;
    swap_at = -1;
    done    = 1'b0;
    for (int i = 0; i <= 150; i++) begin
      if (swap) begin
        n_swap++;
        swap_at = i;
      end
      if (i == 50)
        check("db_sweep_front", 128'(video_memory), 128'(exp_vm));
      if (!busy) begin
        done = 1'b1;
        break;
      end
      vsync = !(i == 10 || i == 11 || i == 30 || i == 31)
              || (i == 10 || i == 30);
      tick();
    end
    check("db_sweep_done", 128'(done), 128'(1));
    check("db_nswap", 128'(n_swap), 128'(1));
    check("db_swap_at", 128'(swap_at), 128'(100));
    check("db_sweep_vm", 128'(video_memory), 128'(0));

    // Reset mid-sweep with a swap pending
    vsync = 1'b1;
    req(2'b01, 9);
    req(2'b11, 0);
    for (int i = 0; i < 40; i++) begin
      vsync = (i != 5);
      tick();
    end
    check("db_rst_busy_pre", 128'(busy), 128'(1));
    rst = 1'b1;
    tick();
    check("db_rst_vm", 128'(video_memory), 128'(0));
    check("db_rst_ready", 128'(wr_ready), 128'(0));
    check("db_rst_busy", 128'(busy), 128'(0));
    check("db_rst_err", 128'(err), 128'(0));
    check("db_rst_swap", 128'(swap), 128'(0));
    rst = 1'b0;
    tick();
    check("db_rst_rel", 128'(wr_ready), 128'(1));
    vsync = 1'b0;
    tick();
    check("db_rst_back0", 128'(video_memory), 128'(0));
    check("db_rst_swap1", 128'(swap), 128'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_writer.md
# vram_writer

Video-memory write stage that sits directly upstream of the VGA scan-out. It owns the 100-cell (10x10) monochrome cell bitmap that the VGA block reads as `video_memory`. It accepts single-cell set/clear/toggle requests and a sequenced clear-all over a valid/ready handshake from the memory/CPU side. Optionally it double-buffers the bitmap so that the scan-out only changes at frame boundaries.

## Interface
Parameters:
- `CELLS`, default 100, number of bitmap cells; width of `video_memory`.
- `IDX_W`, default 7, cell-index width; requires 2^IDX_W >= CELLS.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  request present.
- `wr_ready`  out  1  block can accept a request this cycle.
- `wr_op`  in  2  00 CLR cell, 01 SET cell, 10 TOG cell, 11 CLEAR_ALL.
- `wr_idx`  in  IDX_W  target cell; ignored for CLEAR_ALL.
- `vsync`  in  1  VGA vertical sync, active-low; its falling edge marks the frame boundary.
- `video_memory`  out  CELLS  bitmap presented to the VGA block; bit i = cell i lit.
- `busy`  out  1  CLEAR_ALL sweep in progress.
- `err`  out  1  one-cycle pulse: accepted cell op had `wr_idx >= CELLS`.
- `swap`  out  1  one-cycle pulse: front buffer loaded from back buffer (double-buffer build only; tied 0 otherwise).

## Operation
- Handshake: a transfer occurs on a rising edge where `wr_valid && wr_ready`. Request fields are sampled only on that edge. `wr_valid` may drop or change freely while `wr_ready=0`.
- FSM states:
  - IDLE: `wr_ready=1`, `busy=0`.
  - SWEEP: `wr_ready=0`, `busy=1`.
- IDLE, accepted CLR/SET/TOG with `wr_idx < CELLS`: the working buffer bit is updated (0 / 1 / inverted). The FSM stays in IDLE.
- IDLE, accepted cell op with `wr_idx >= CELLS`: the transfer completes, no bit changes, and `err=1` on the next cycle.
- IDLE, accepted CLEAR_ALL: the sweep pointer is set to 0 and the FSM moves to SWEEP.
- SWEEP: clears working bit[ptr] each cycle and increments ptr. After clearing bit CELLS-1 the FSM returns to IDLE. The sweep takes exactly CELLS cycles.
- The working buffer is the back buffer when `VRAM_DOUBLE_BUFFER_EN` is defined, otherwise `video_memory` itself.
- Frame edge detection: `vsync` is registered into `vs_q`. A frame edge is the cycle where `vs_q=1` and `vsync=0`.
- Double-buffer swap: on a frame edge outside SWEEP, the front is loaded from the back on that clock edge. If a cell write is accepted in the same cycle, the front receives the pre-write back value and the write lands in the back only.
- Frame edge during SWEEP: a pending flag is set. The swap happens on the edge that clears cell CELLS-1, and the front receives the fully cleared back buffer. Multiple edges during one sweep produce one swap.
- The back buffer is never cleared by a swap.

## Timing
- Reset values: `video_memory=0`, back buffer=0, `wr_ready=0`, `busy=0`, `err=0`, `swap=0`, `vs_q=1`, pending=0, FSM=IDLE, ptr=0.
- `wr_ready` is registered. It rises the first cycle after `rst` deasserts.
- Cell-op latency, direct mode: the accepting edge updates `video_memory`, visible 1 cycle after acceptance.
- Cell-op latency, double mode: the back buffer updates on the accepting edge; the front updates at the next frame edge.
- CLEAR_ALL accepted at edge E:
  - `wr_ready=0` and `busy=1` from E through E+CELLS.
  - In direct mode, bit k reads 0 after edge E+1+k.
  - `wr_ready=1` again after edge E+CELLS.
- `err` and `swap` are high for exactly one cycle and are registered.
- `rst` asserted mid-sweep or with a swap pending: everything returns to reset values at that edge and the sweep is abandoned.

## Configuration
- `VRAM_DOUBLE_BUFFER_EN` defined: the back buffer, frame-edge swap, pending flag and `swap` pulse are built. Writes reach `video_memory` only at frame edges.
- `VRAM_DOUBLE_BUFFER_EN` not defined: single buffer only. `vsync` is unused, `swap` is tied 0, and writes are visible one cycle after acceptance.

## Test plan
- Reset then SET idx 50 (direct) → `wr_ready=1` one cycle after reset; `video_memory[50]=1` one cycle after acceptance; all other bits 0.
- SET 3, TOG 3, TOG 3, CLR 3 back-to-back (direct) → bit 3 reads 1, 0, 1, 0 on successive cycles; `err` never asserted.
- SET idx 100 and idx 127 → handshake completes; `video_memory` unchanged; `err` pulses one cycle per request.
- SET cells 0, 50, 99, then CLEAR_ALL → `wr_ready=0` and `busy=1` for exactly 100 cycles; bit 50 reads 0 after edge E+51; `video_memory=0` at the end.
- Double buffer: SET 7, then `vsync` falls at cycle T → `video_memory[7]=0` until edge T; `video_memory[7]=1` and `swap=1` after edge T. A SET 8 in cycle T appears only after the next frame edge.
- Double buffer: two `vsync` falls during a sweep, and `rst` asserted at sweep cycle 40 in a second run → first run gives a single `swap` on the final sweep edge with front all-zero. In the reset run, all outputs equal their reset values after the reset edge and `wr_ready=1` one cycle after release.
